// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: widths, opcodes,
// decode bundle and small combinational helpers.
package operand_fetch_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic rs1_used;
        logic rs2_used;
        logic rd_we;
    } rf_use_t;

    // A register is busy if an older producer has not yet written it back,
    // or if the producer is still sitting in our own output register.
    function automatic logic f_hazard(
        input logic          used,
        input logic [AW-1:0] a,
        input logic          pend,
        input logic          wb_hit,
        input logic          out_hit
    );
        return used && (a != '0) && ((pend && !wb_hit) || out_hit);
    endfunction

    function automatic logic [XLEN-1:0] f_operand(
        input logic [AW-1:0]   a,
        input logic            wb_hit,
        input logic [XLEN-1:0] wb_wd,
        input logic [XLEN-1:0] rdata
    );
        if (a == '0)
            return '0;
        else if (wb_hit)
            return wb_wd;
        else
            return rdata;
    endfunction

endpackage

// File: rtl/operand_fetch_rf_use_decode.sv
// Opcode to register-file usage decode: which sources are read and
// whether a destination is written.
module operand_fetch_rf_use_decode
    import operand_fetch_pkg::*;
(
    input  logic [6:0] i_opcode,
    output rf_use_t    o_use
);

    always_comb begin
        o_use = '0;
        unique case (i_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                o_use.rd_we = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                o_use.rs1_used = 1'b1;
                o_use.rd_we    = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                o_use.rs1_used = 1'b1;
                o_use.rs2_used = 1'b1;
            end
            OPC_OP: begin
                o_use.rs1_used = 1'b1;
                o_use.rs2_used = 1'b1;
                o_use.rd_we    = 1'b1;
            end
            default: o_use = '0;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-read stage: RegFile read, writeback bypass, pending-write
// scoreboard with RAW/WAW stall, and a one-entry registered output.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [AW-1:0]   ra1,
    output logic [AW-1:0]   ra2,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [AW-1:0]   out_rd,
    output logic            out_rd_we
);

    logic            r_out_valid;
    logic [31:0]     r_out_inst;
    logic [XLEN-1:0] r_out_pc;
    logic [XLEN-1:0] r_out_op1;
    logic [XLEN-1:0] r_out_op2;
    logic [AW-1:0]   r_out_rd;
    logic            r_out_rd_we;
    logic [NREG-1:0] r_pending;

    rf_use_t         w_use;
    logic [AW-1:0]   w_rd;
    logic            w_rd_we;
    logic            w_wb_hit1;
    logic            w_wb_hit2;
    logic            w_wb_hitd;
    logic            w_haz1;
    logic            w_haz2;
    logic            w_hazd;
    logic            w_stall;
    logic            w_accept;
    logic            w_handoff;
    logic [NREG-1:0] w_pend_nxt;

    operand_fetch_rf_use_decode u_dec (
        .i_opcode (in_inst[6:0]),
        .o_use    (w_use)
    );

    assign ra1     = in_inst[19:15];
    assign ra2     = in_inst[24:20];
    assign w_rd    = in_inst[11:7];
    assign w_rd_we = w_use.rd_we && (w_rd != '0);

    assign w_wb_hit1 = wb_we && (wb_wa == ra1);
    assign w_wb_hit2 = wb_we && (wb_wa == ra2);
    assign w_wb_hitd = wb_we && (wb_wa == w_rd);

    assign w_haz1 = f_hazard(w_use.rs1_used, ra1, r_pending[ra1], w_wb_hit1,
                             r_out_valid && r_out_rd_we && (r_out_rd == ra1));
    assign w_haz2 = f_hazard(w_use.rs2_used, ra2, r_pending[ra2], w_wb_hit2,
                             r_out_valid && r_out_rd_we && (r_out_rd == ra2));
    assign w_hazd = f_hazard(w_rd_we, w_rd, r_pending[w_rd], w_wb_hitd,
                             r_out_valid && r_out_rd_we && (r_out_rd == w_rd));

    assign w_stall   = w_haz1 || w_haz2 || w_hazd;
    assign in_ready  = !w_stall && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready && !flush;
    // A flushed entry never reaches execute, so it must not claim its rd.
    assign w_handoff = r_out_valid && out_ready && !flush;

    always_comb begin
        w_pend_nxt = r_pending;
        if (wb_we)
            w_pend_nxt[wb_wa] = 1'b0;
        if (w_handoff && r_out_rd_we)
            w_pend_nxt[r_out_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pc    <= '0;
            r_out_op1   <= '0;
            r_out_op2   <= '0;
            r_out_rd    <= '0;
            r_out_rd_we <= 1'b0;
            r_pending   <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_inst  <= in_inst;
                r_out_pc    <= in_pc;
                r_out_op1   <= f_operand(ra1, w_wb_hit1, wb_wd, rd1);
                r_out_op2   <= f_operand(ra2, w_wb_hit2, wb_wd, rd2);
                r_out_rd    <= w_rd;
                r_out_rd_we <= w_rd_we;
            end else if (w_handoff) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_pc    = r_out_pc;
    assign out_op1   = r_out_op1;
    assign out_op2   = r_out_op2;
    assign out_rd    = r_out_rd;
    assign out_rd_we = r_out_rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: RegFile model, scoreboard queue of expected
// execute bundles, and directed hazard/bypass/flush sequences.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_we;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rd_we;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    logic        nxt_rd_we;
    logic [31:0] rf [32];
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .wb_we     (wb_we),
        .wb_wa     (wb_wa),
        .wb_wd     (wb_wd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd),
        .out_rd_we (out_rd_we)
    );

    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= 32'h100 + i;
        end else if (wb_we && wb_wa != 5'd0) begin
            rf[wb_wa] <= wb_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_op(input logic [4:0] a);
        if (a == 5'd0)
            return 32'd0;
        else if (wb_we && wb_wa == a)
            return wb_wd;
        else
            return rf[a];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready && !flush) begin
                if (q.size() == 0) begin
                    chk("q_nonempty", 32'(q.size()), 32'd1);
                end else begin
                    m_e = q.pop_front();
                    chk("o_inst", out_inst, m_e.inst);
                    chk("o_pc", out_pc, m_e.pc);
                    chk("o_op1", out_op1, m_e.op1);
                    chk("o_op2", out_op2, m_e.op2);
                    chk("o_rd", 32'(out_rd), 32'(m_e.rd));
                    chk("o_rd_we", 32'(out_rd_we), 32'(m_e.rd_we));
                end
            end
            if (in_valid && in_ready && !flush) begin
                m_e.inst  = in_inst;
                m_e.pc    = in_pc;
                m_e.op1   = exp_op(in_inst[19:15]);
                m_e.op2   = exp_op(in_inst[24:20]);
                m_e.rd    = in_inst[11:7];
                m_e.rd_we = nxt_rd_we;
                q.push_back(m_e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        out_ready = 1'b1; flush = 1'b0; nxt_rd_we = 1'b0;
        wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_pend", dut.r_pending, 32'd0);
        chk("rst_iready", 32'(in_ready), 32'd1);
        chk("rst_op1", out_op1, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        cyc();
        rst_n = 1'b1;

        // addi x5,x0,7 held in output, then handed off
        in_valid = 1'b1; in_inst = 32'h00700293; in_pc = 32'h100;
        nxt_rd_we = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_ov", 32'(out_valid), 32'd1);
        chk("t2_rd", 32'(out_rd), 32'd5);
        chk("t2_rdwe", 32'(out_rd_we), 32'd1);
        chk("t2_op1", out_op1, 32'd0);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("t2_pend", dut.r_pending, 32'h20);
        chk("t2_ov_drop", 32'(out_valid), 32'd0);

        // add x6,x5,x5 stalls until x5 writes back, then bypasses
        cyc();
        in_valid = 1'b1; in_inst = 32'h00528333; in_pc = 32'h104;
        nxt_rd_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall", 32'(in_ready), 32'd0);
            cyc();
        end
        wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h7;
        @(negedge clk);
        chk("t3_release", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        chk("t3_pend_clr", dut.r_pending, 32'd0);
        cyc();
        @(negedge clk);
        chk("t3_pend6", dut.r_pending, 32'h40);
        cyc();
        wb_we = 1'b1; wb_wa = 5'd6; wb_wd = 32'h66;
        @(negedge clk);
        cyc();
        wb_we = 1'b0;
        @(negedge clk);
        chk("t3_pend_end", dut.r_pending, 32'd0);

        // add x7,x5,x0 behind a held addi x5
        cyc();
        in_valid = 1'b1; in_inst = 32'h00700293; in_pc = 32'h108;
        nxt_rd_we = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        cyc();
        in_inst = 32'h000283B3; in_pc = 32'h10C;
        @(negedge clk);
        chk("t4_hold", 32'(in_ready), 32'd0);
        chk("t4_ov", 32'(out_valid), 32'd1);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_outhit", 32'(in_ready), 32'd0);
        cyc();
        @(negedge clk);
        chk("t4_pendstall", 32'(in_ready), 32'd0);
        chk("t4_pend5", dut.r_pending, 32'h20);
        cyc();
        wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h55;
        @(negedge clk);
        chk("t4_release", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("t4_pend7", dut.r_pending, 32'h80);
        cyc();
        wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'h77;
        @(negedge clk);
        cyc();
        wb_we = 1'b0;
        @(negedge clk);
        chk("t4_pend_end", dut.r_pending, 32'd0);

        // x0 ignores a write to x0; store and branch never own rd
        cyc();
        in_valid = 1'b1; in_inst = 32'h000000B3; in_pc = 32'h110;
        nxt_rd_we = 1'b1;
        wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'hFFFF;
        @(negedge clk);
        cyc();
        in_inst = 32'h00532023; in_pc = 32'h114; nxt_rd_we = 1'b0;
        wb_we = 1'b0;
        @(negedge clk);
        cyc();
        in_inst = 32'h00000463; in_pc = 32'h118; nxt_rd_we = 1'b0;
        @(negedge clk);
        chk("t5_pend1", dut.r_pending, 32'h2);
        cyc();
        in_valid = 1'b0;
        wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'h11;
        @(negedge clk);
        cyc();
        wb_we = 1'b0;
        @(negedge clk);
        chk("t5_nopend", dut.r_pending, 32'd0);

        // flush squashes held addi x8 and the offered instruction
        cyc();
        in_valid = 1'b1; in_inst = 32'h00100413; in_pc = 32'h120;
        nxt_rd_we = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        cyc();
        in_inst = 32'h00200493; in_pc = 32'h124;
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("t6_pre_ov", 32'(out_valid), 32'd1);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        if (q.size() > 0)
            q.delete(0);
        @(negedge clk);
        chk("t6_ov", 32'(out_valid), 32'd0);
        chk("t6_pend", dut.r_pending, 32'd0);
        cyc();
        @(negedge clk);
        chk("t6_not_taken", 32'(out_valid), 32'd0);
        chk("q_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
